// File: rtl/othello_pkg.sv
// Shared Othello types: stone and winner codes, and the score counter FSM states.
package othello_pkg;

  typedef enum logic [1:0] {
    STONE_WHITE = 2'b00,
    STONE_BLACK = 2'b01,
    STONE_EMPTY = 2'b10
  } stone_t;

  typedef enum logic [1:0] {
    WIN_WHITE = 2'b00,
    WIN_BLACK = 2'b01,
    WIN_TIE   = 2'b10
  } winner_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SCAN = 2'b01,
    ST_FIN  = 2'b10,
    ST_HOLD = 2'b11
  } state_t;

  function automatic winner_t winner_of(input logic [31:0] black, input logic [31:0] white);
    if (black > white) return WIN_BLACK;
    if (white > black) return WIN_WHITE;
    return WIN_TIE;
  endfunction

endpackage

// File: rtl/board_score_counter_if.sv
// Bus between the game-control FSM / display side and the board score counter.
interface board_score_counter_if
  import othello_pkg::*;
#(
  parameter int BOARD_N = 8
);
  localparam int CNT_W = $clog2(BOARD_N*BOARD_N+1);

  // i_start is a request taken only when the counter is idle or holding (o_busy low);
  // o_done is a one-cycle valid pulse, with counts/winner settled from the next cycle on.
  logic                                 i_start;
  logic                                 i_clear;
  logic [0:BOARD_N-1][0:BOARD_N-1][1:0] i_board;
  logic [CNT_W-1:0]                     o_black;
  logic [CNT_W-1:0]                     o_white;
  logic [CNT_W-1:0]                     o_empty;
  logic [1:0]                           o_winner;
  logic                                 o_busy;
  logic                                 o_done;
  state_t                               state;

  modport master (
    output i_start, i_clear, i_board,
    input  o_black, o_white, o_empty, o_winner, o_busy, o_done, state
  );

  modport slave (
    input  i_start, i_clear, i_board,
    output o_black, o_white, o_empty, o_winner, o_busy, o_done, state
  );

endinterface

// File: rtl/board_lane_tally.sv
// Combinational tally of black and white stones among one column group of LANES cells.
module board_lane_tally
  import othello_pkg::*;
#(
  parameter int LANES = 1
) (
  input  stone_t [LANES-1:0]         cells,
  output logic [$clog2(LANES+1)-1:0] black,
  output logic [$clog2(LANES+1)-1:0] white
);
  localparam int TW = $clog2(LANES+1);

  always_comb begin
    black = '0;
    white = '0;
    for (int i = 0; i < LANES; i++) begin
      if (cells[i] == STONE_BLACK) black = black + TW'(1);
      if (cells[i] == STONE_WHITE) white = white + TW'(1);
    end
  end

endmodule

// File: rtl/board_score_counter.sv
// Column-major N x N board scan, LANES cells per cycle, with winner decision held until next scan.
// Optional: define BOARD_SCORE_EMPTY_TO_WINNER_EN to give the empty squares to the leading colour.
module board_score_counter
  import othello_pkg::*;
#(
  parameter int BOARD_N = 8,
  parameter int LANES   = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  board_score_counter_if.slave bus
);
  localparam int CNT_W = $clog2(BOARD_N*BOARD_N+1);
  localparam int PW    = $clog2(BOARD_N);
  localparam int TW    = $clog2(LANES+1);
  localparam logic [PW-1:0] LAST_ROW = PW'(BOARD_N - LANES);
  localparam logic [PW-1:0] LAST_COL = PW'(BOARD_N - 1);
  localparam logic [PW-1:0] ROW_STEP = PW'(LANES % BOARD_N);

  state_t           state_q, state_d;
  logic [PW-1:0]    row_q, col_q;
  logic [CNT_W-1:0] black_q, white_q, empty_q;
  logic [CNT_W-1:0] fin_black, fin_white, fin_empty;
  winner_t          winner_q;
  stone_t [LANES-1:0] lane_cells;
  logic [TW-1:0]    lane_black, lane_white, lane_empty;
  logic             last_group;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [PW-1:0] row_idx;
    assign row_idx       = row_q + PW'(i);
    assign lane_cells[i] = stone_t'(bus.i_board[row_idx][col_q]);
  end

  board_lane_tally #(.LANES(LANES)) u_tally (
    .cells (lane_cells),
    .black (lane_black),
    .white (lane_white)
  );

  assign lane_empty = TW'(LANES) - lane_black - lane_white;
  assign last_group = (row_q == LAST_ROW) && (col_q == LAST_COL);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_HOLD: if (bus.i_start) state_d = ST_SCAN;
      ST_SCAN:          if (last_group) state_d = ST_FIN;
      ST_FIN:           state_d = ST_HOLD;
      default:          state_d = ST_IDLE;
    endcase
    if (bus.i_clear) state_d = ST_IDLE;
  end

  // Final adjustment applied while in FIN; raw counts otherwise.
  always_comb begin
    fin_black = black_q;
    fin_white = white_q;
    fin_empty = empty_q;
`ifdef BOARD_SCORE_EMPTY_TO_WINNER_EN
    if (black_q > white_q) begin
      fin_black = black_q + empty_q;
      fin_empty = '0;
    end else if (white_q > black_q) begin
      fin_white = white_q + empty_q;
      fin_empty = '0;
    end
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      row_q    <= '0;
      col_q    <= '0;
      black_q  <= '0;
      white_q  <= '0;
      empty_q  <= '0;
      winner_q <= WIN_TIE;
    end else if (bus.i_clear) begin
      state_q  <= ST_IDLE;
      row_q    <= '0;
      col_q    <= '0;
      black_q  <= '0;
      white_q  <= '0;
      empty_q  <= '0;
      winner_q <= WIN_TIE;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE, ST_HOLD: begin
          if (bus.i_start) begin
            row_q   <= '0;
            col_q   <= '0;
            black_q <= '0;
            white_q <= '0;
            empty_q <= '0;
          end
        end
        ST_SCAN: begin
          black_q <= black_q + CNT_W'(lane_black);
          white_q <= white_q + CNT_W'(lane_white);
          empty_q <= empty_q + CNT_W'(lane_empty);
          if (row_q == LAST_ROW) begin
            row_q <= '0;
            col_q <= col_q + PW'(1);
          end else begin
            row_q <= row_q + ROW_STEP;
          end
        end
        ST_FIN: begin
          black_q  <= fin_black;
          white_q  <= fin_white;
          empty_q  <= fin_empty;
          winner_q <= winner_of(32'(fin_black), 32'(fin_white));
        end
        default: ;
      endcase
    end
  end

  assign bus.o_black  = black_q;
  assign bus.o_white  = white_q;
  assign bus.o_empty  = empty_q;
  assign bus.o_winner = winner_q;
  assign bus.o_busy   = (state_q == ST_SCAN) || (state_q == ST_FIN);
  assign bus.o_done   = (state_q == ST_FIN);
  assign bus.state    = state_q;

endmodule
